// File: rtl/id_operand_stage.sv
// ID/EX operand stage: decodes the instruction, reads operands, detects load-use hazards and registers the ID/EX contents.
// Optional macro WB_BYPASS_EN forwards the write-back port into the operands instead of stalling on a match.
module id_operand_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [4:0]  rf_r1_addr,
  output logic [4:0]  rf_r2_addr,
  input  logic [31:0] rf_r1_dout,
  input  logic [31:0] rf_r2_dout,
  input  logic        wb_wr,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_din,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_wr,
  output logic        ex_is_load,
  output logic [15:0] hazard_cnt
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, dest;
  logic        reg_wr, is_load, rt_used;
  logic [31:0] imm, rs_val, rt_val;
  logic        wb_hit_rs, wb_hit_rt, load_use, hazard;

  assign opcode     = if_instr[31:26];
  assign rs         = if_instr[25:21];
  assign rt         = if_instr[20:16];
  assign rf_r1_addr = rs;
  assign rf_r2_addr = rt;

  always_comb begin
    case (opcode)
      6'd0:    dest = if_instr[15:11];
      6'd3:    dest = 5'd31;
      default: dest = rt;
    endcase
    reg_wr  = (opcode inside {6'd0, 6'd3, [6'd8:6'd15], 6'd32, 6'd33, [6'd35:6'd37]}) && (dest != '0);
    is_load = opcode inside {6'd32, 6'd33, [6'd35:6'd37]};
    rt_used = opcode inside {6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43};
    if (opcode inside {6'd12, 6'd13, 6'd14})
      imm = {16'h0000, if_instr[15:0]};
    else
      imm = {{16{if_instr[15]}}, if_instr[15:0]};
  end

  // The wb mux is kept in both builds: without bypass a match always bubbles,
  // so the forwarded value is never captured and behaviour is unchanged.
  always_comb begin
    wb_hit_rs = wb_wr && (wb_addr != '0) && (wb_addr == rs);
    wb_hit_rt = wb_wr && (wb_addr != '0) && (wb_addr == rt) && rt_used;
    load_use  = if_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                ((ex_rd == rs) || (rt_used && (ex_rd == rt)));
`ifdef WB_BYPASS_EN
    hazard    = load_use;
`else
    hazard    = load_use || (if_valid && (wb_hit_rs || wb_hit_rt));
`endif
    rs_val = wb_hit_rs ? wb_din : rf_r1_dout;
    rt_val = wb_hit_rt ? wb_din : rf_r2_dout;
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

  assign id_stall = !flush && (ex_stall || hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_instr   <= NOP_INSTR;
      ex_rs_val  <= '0;
      ex_rt_val  <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_reg_wr  <= 1'b0;
      ex_is_load <= 1'b0;
      hazard_cnt <= '0;
    end else if (flush || (!ex_stall && hazard)) begin
      ex_valid   <= 1'b0;
      ex_instr   <= NOP_INSTR;
      ex_reg_wr  <= 1'b0;
      ex_is_load <= 1'b0;
      if (!flush && (hazard_cnt != 16'hFFFF))
        hazard_cnt <= hazard_cnt + 16'd1;
    end else if (!ex_stall) begin
      ex_valid   <= if_valid;
      ex_pc      <= if_pc;
      ex_instr   <= if_instr;
      ex_rs_val  <= rs_val;
      ex_rt_val  <= rt_val;
      ex_imm     <= imm;
      ex_rd      <= dest;
      ex_reg_wr  <= if_valid && reg_wr;
      ex_is_load <= if_valid && is_load;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed vectors push expected id_stall / ID-EX values, a negedge monitor compares.
module tb_id_operand_stage;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, flush, ex_stall, wb_wr;
  logic [31:0] if_instr, if_pc, wb_din;
  logic [4:0]  wb_addr;
  logic [4:0]  rf_r1_addr, rf_r2_addr;
  logic [31:0] rf_r1_dout, rf_r2_dout;
  logic        id_stall, ex_valid, ex_reg_wr, ex_is_load;
  logic [31:0] ex_pc, ex_instr, ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [15:0] hazard_cnt;

  logic [31:0] regs [32];
  assign rf_r1_dout = regs[rf_r1_addr];
  assign rf_r2_dout = regs[rf_r2_addr];

  id_operand_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_stall(ex_stall), .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
    .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout), .wb_wr(wb_wr), .wb_addr(wb_addr),
    .wb_din(wb_din), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    bit          is_ex;
    bit          full;
    logic        stall;
    logic        valid;
    logic [31:0] instr, pc, rs, rt, imm;
    logic [4:0]  rd;
    logic        wr, ld;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] cnt_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // hand-assembled instructions
  localparam logic [31:0] I_ADD   = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C24_0000; // lw   $4,0($1)
  localparam logic [31:0] I_ADDU  = 32'h0082_2820; // add  $5,$4,$2
  localparam logic [31:0] I_OR    = 32'h00C0_3825; // or   $7,$6,$0
  localparam logic [31:0] I_SW    = 32'hAC24_0008; // sw   $4,8($1)
  localparam logic [31:0] I_ADDI  = 32'h2024_FFFF; // addi $4,$1,-1
  localparam logic [31:0] I_ORI   = 32'h3428_8000; // ori  $8,$1,0x8000
  localparam logic [31:0] I_LW0   = 32'h8C20_0000; // lw   $0,0($1)
  localparam logic [31:0] I_ADD00 = 32'h0000_2820; // add  $5,$0,$0
  localparam logic [31:0] I_JAL   = 32'h0C00_0010; // jal  0x10

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t ex_full(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                                   input logic [4:0] rd, input logic wr, input logic ld);
    exp_t e;
    e = '{default: 0};
    e.is_ex = 1'b1; e.full = 1'b1; e.valid = v; e.instr = ins; e.pc = pc;
    e.rs = rs; e.rt = rt; e.imm = imm; e.rd = rd; e.wr = wr; e.ld = ld; e.cnt = cnt_exp;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '{default: 0};
    e.is_ex = 1'b1; e.valid = 1'b0; e.instr = NOP; e.wr = 1'b0; e.ld = 1'b0; e.cnt = cnt_exp;
    return e;
  endfunction

  task automatic push_exp(input exp_t e, input int unsigned due);
    e.due = due;
    q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic fl, input logic st, input logic exp_st, input exp_t e);
    exp_t s;
    if_instr = ins; if_pc = pc; if_valid = v; flush = fl; ex_stall = st;
    s = '{default: 0};
    s.stall = exp_st;
    push_exp(s, cyc);
    push_exp(e, cyc + 1);
    @(posedge clk); #1;
  endtask

  // monitor
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due <= cyc) begin
        it = q.pop_front();
        if (it.due != cyc) chk("late_item", cyc, it.due);
        else if (!it.is_ex) chk("id_stall", 32'(id_stall), 32'(it.stall));
        else begin
          chk("ex_valid", 32'(ex_valid), 32'(it.valid));
          chk("ex_instr", ex_instr, it.instr);
          chk("ex_reg_wr", 32'(ex_reg_wr), 32'(it.wr));
          chk("ex_is_load", 32'(ex_is_load), 32'(it.ld));
          chk("hazard_cnt", 32'(hazard_cnt), 32'(it.cnt));
          if (it.full) begin
            chk("ex_pc", ex_pc, it.pc);
            chk("ex_rs_val", ex_rs_val, it.rs);
            chk("ex_rt_val", ex_rt_val, it.rt);
            chk("ex_imm", ex_imm, it.imm);
            chk("ex_rd", 32'(ex_rd), 32'(it.rd));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'hBAD0_0000; regs[1] = 32'd5; regs[2] = 32'd7;
    regs[4] = 32'h44; regs[6] = 32'h1111_1111; regs[8] = 32'h88;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_stall = 1'b0;
    wb_wr = 1'b0; wb_addr = '0; wb_din = '0;

    repeat (2) @(posedge clk);
    #1;
    push_exp(ex_full(0, NOP, 0, 0, 0, 0, 0, 0, 0), cyc);
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_exp(ex_full(0, 32'h0, 0, 0, 0, 0, 0, 0, 0), cyc + 1);
    @(posedge clk); #1;

    drive(I_ADD, 32'h100, 1, 0, 0, 0, ex_full(1, I_ADD, 32'h100, 5, 7, 32'h1820, 3, 1, 0));
    drive(I_LW, 32'h104, 1, 0, 0, 0, ex_full(1, I_LW, 32'h104, 5, 32'h44, 0, 4, 1, 1));
    cnt_exp = 16'd1;
    drive(I_ADDU, 32'h108, 1, 0, 0, 1, bub());
    drive(I_ADDU, 32'h108, 1, 0, 0, 0, ex_full(1, I_ADDU, 32'h108, 32'h44, 7, 32'h2820, 5, 1, 0));

    wb_wr = 1'b1; wb_addr = 5'd6; wb_din = 32'hDEAD_BEEF;
`ifdef WB_BYPASS_EN
    drive(I_OR, 32'h10C, 1, 0, 0, 0, ex_full(1, I_OR, 32'h10C, 32'hDEAD_BEEF, 0, 32'h3825, 7, 1, 0));
    wb_wr = 1'b0;
`else
    cnt_exp = 16'd2;
    drive(I_OR, 32'h10C, 1, 0, 0, 1, bub());
    regs[6] = 32'hDEAD_BEEF; wb_wr = 1'b0;
    drive(I_OR, 32'h10C, 1, 0, 0, 0, ex_full(1, I_OR, 32'h10C, 32'hDEAD_BEEF, 0, 32'h3825, 7, 1, 0));
`endif

    // flush + ex_stall on top of a load-use hazard
    drive(I_LW, 32'h110, 1, 0, 0, 0, ex_full(1, I_LW, 32'h110, 5, 32'h44, 0, 4, 1, 1));
    drive(I_ADDU, 32'h114, 1, 1, 1, 0, bub());

    // ex_stall held for three cycles
    drive(I_ADD, 32'h200, 1, 0, 0, 0, ex_full(1, I_ADD, 32'h200, 5, 7, 32'h1820, 3, 1, 0));
    for (int i = 0; i < 3; i++)
      drive(I_LW, 32'h204, 1, 0, 1, 1, ex_full(1, I_ADD, 32'h200, 5, 7, 32'h1820, 3, 1, 0));
    drive(I_LW, 32'h204, 1, 0, 0, 0, ex_full(1, I_LW, 32'h204, 5, 32'h44, 0, 4, 1, 1));

    // rt-side load-use on a store
    cnt_exp = cnt_exp + 16'd1;
    drive(I_SW, 32'h208, 1, 0, 0, 1, bub());
    drive(I_SW, 32'h208, 1, 0, 0, 0, ex_full(1, I_SW, 32'h208, 5, 32'h44, 8, 4, 0, 0));

    // rt not a source for addi, so no hazard; immediate sign/zero extension
    drive(I_LW, 32'h20C, 1, 0, 0, 0, ex_full(1, I_LW, 32'h20C, 5, 32'h44, 0, 4, 1, 1));
    drive(I_ADDI, 32'h210, 1, 0, 0, 0, ex_full(1, I_ADDI, 32'h210, 5, 32'h44, 32'hFFFF_FFFF, 4, 1, 0));
    drive(I_ORI, 32'h214, 1, 0, 0, 0, ex_full(1, I_ORI, 32'h214, 5, 32'h88, 32'h0000_8000, 8, 1, 0));

    // load to $0 never causes a hazard and never writes
    drive(I_LW0, 32'h218, 1, 0, 0, 0, ex_full(1, I_LW0, 32'h218, 5, 0, 0, 0, 0, 1));
    drive(I_ADD00, 32'h21C, 1, 0, 0, 0, ex_full(1, I_ADD00, 32'h21C, 0, 0, 32'h2820, 5, 1, 0));

    drive(I_LW, 32'h220, 0, 0, 0, 0, ex_full(0, I_LW, 32'h220, 5, 32'h44, 0, 4, 0, 0));
    drive(I_JAL, 32'h224, 1, 0, 0, 0, ex_full(1, I_JAL, 32'h224, 0, 0, 32'h10, 31, 1, 0));

    wb_wr = 1'b1; wb_addr = 5'd0; wb_din = 32'h1234_5678;
    drive(I_ADD00, 32'h228, 1, 0, 0, 0, ex_full(1, I_ADD00, 32'h228, 0, 0, 32'h2820, 5, 1, 0));
    wb_wr = 1'b0;

`ifndef WB_BYPASS_EN
    // a standing write-back match on rs stalls every cycle: drive the counter into saturation
    wb_wr = 1'b1; wb_addr = 5'd1; wb_din = 32'h5555_5555;
    for (int i = 0; i < 65540; i++) begin
      if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
      drive(I_ADD, 32'h300, 1, 0, 0, 1, bub());
    end
    wb_wr = 1'b0;
`endif
    drive(I_ADD, 32'h304, 1, 0, 0, 0, ex_full(1, I_ADD, 32'h304, 5, 7, 32'h1820, 3, 1, 0));

    // reset in the middle of a stall drops the held instruction
    drive(I_LW, 32'h308, 1, 0, 1, 1, ex_full(1, I_ADD, 32'h304, 5, 7, 32'h1820, 3, 1, 0));
    @(negedge clk); #1;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_stall = 1'b0;
    cnt_exp = '0;
    push_exp(ex_full(0, NOP, 0, 0, 0, 0, 0, 0, 0), cyc + 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_exp(ex_full(0, 32'h0, 0, 0, 0, 0, 0, 0, 0), cyc + 1);
    @(posedge clk); #1;
    drive(I_ADD, 32'h400, 1, 0, 0, 0, ex_full(1, I_ADD, 32'h400, 5, 7, 32'h1820, 3, 1, 0));

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
